// File: rtl/uart_wb_bridge_if.sv
// Signal bundle between the UART byte streams, the bridge and the DDR3 Wishbone port.
// The bridge uses the master view; the UART/controller side uses the slave view.
interface uart_wb_bridge_if #(
    parameter int WB_ADDR_BITS    = 8,
    parameter int WB_DATA_BITS    = 128,
    parameter int AUX_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [7:0]                s_axis_tdata;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic [7:0]                m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      o_wb_cyc;
    logic                      o_wb_stb;
    logic                      o_wb_we;
    logic [WB_ADDR_BITS-1:0]   o_wb_addr;
    logic [WB_DATA_BITS-1:0]   o_wb_data;
    logic [WB_DATA_BITS/8-1:0] o_wb_sel;
    logic [AUX_WIDTH-1:0]      o_aux;
    logic                      i_wb_stall;
    logic                      i_wb_ack;
    logic [WB_DATA_BITS-1:0]   i_wb_data;
    logic [AUX_WIDTH-1:0]      i_aux;
    logic [OW-1:0]             o_outstanding;
    logic                      o_err;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  i_wb_stall, i_wb_ack, i_wb_data, i_aux,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_aux,
        output o_outstanding, o_err
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output i_wb_stall, i_wb_ack, i_wb_data, i_aux,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_aux,
        input  o_outstanding, o_err
    );
endinterface

// File: rtl/uart_wb_bridge.sv
// UART command bridge: lowercase bytes write DDR3, uppercase bytes read it back to UART TX.
// Read issue reserves a response FIFO slot up front so returning read data always has room.
//   state  | meaning
//   S_IDLE | decode RX FIFO head; discard non-letters, issue letters when limits allow
//   S_REQ  | Wishbone strobe held until accepted; may chain the next head on accept
module uart_wb_bridge #(
    parameter int WB_ADDR_BITS    = 8,
    parameter int WB_DATA_BITS    = 128,
    parameter int AUX_WIDTH       = 4,
    parameter int IN_DEPTH        = 4,
    parameter int RESP_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_wb_bridge_if.master bus
);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int RAW = $clog2(RESP_DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;
    state_t state_q, state_d;

    logic [7:0]   rx_mem_q [IN_DEPTH];
    logic [7:0]   rx_mem_d [IN_DEPTH];
    logic [IAW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt;
    logic         rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]   head, head_low;
    logic         head_lower, head_upper, head_letter;

    logic [7:0]   resp_mem_q [RESP_DEPTH];
    logic [7:0]   resp_mem_d [RESP_DEPTH];
    logic [RAW:0] resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d, resp_cnt, resp_after;
    logic         resp_full, resp_empty, resp_push, resp_pop;

    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d, data_q, data_d;
    logic [OW-1:0] out_q, out_d;
    logic [RAW:0]  rif_q, rif_d;
    logic          err_q, err_d;
    logic          stb, accept, ack_ok, ack_read, issue_ok;
    logic [RAW+1:0] credit_use;
    logic          unused_bits;

    assign rx_cnt      = rx_wr_q - rx_rd_q;
    assign rx_full     = (rx_cnt == (IAW+1)'(IN_DEPTH));
    assign rx_empty    = (rx_cnt == '0);
    assign rx_push     = bus.s_axis_tvalid && !rx_full;
    assign head        = rx_mem_q[rx_rd_q[IAW-1:0]];
    assign head_lower  = (head >= 8'd97) && (head <= 8'd122);
    assign head_upper  = (head >= 8'd65) && (head <= 8'd90);
    assign head_letter = head_lower || head_upper;
    assign head_low    = head_lower ? head : head + 8'd32;

    assign resp_cnt   = resp_wr_q - resp_rd_q;
    assign resp_full  = (resp_cnt == (RAW+1)'(RESP_DEPTH));
    assign resp_empty = (resp_cnt == '0);

    always_comb begin : datapath
        stb        = (state_q == S_REQ);
        accept     = stb && !bus.i_wb_stall;
        ack_ok     = bus.i_wb_ack && (out_q != '0);
        ack_read   = ack_ok && !bus.i_aux[0];
        err_d      = err_q || (bus.i_wb_ack && (out_q == '0));
        out_d      = out_q + OW'(accept) - OW'(ack_ok);
        rif_d      = rif_q + (RAW+1)'(accept && !we_q) - (RAW+1)'(ack_read && (rif_q != '0));
        resp_push  = ack_read && !resp_full;
        resp_pop   = !resp_empty && bus.m_axis_tready;
        resp_wr_d  = resp_wr_q + (RAW+1)'(resp_push);
        resp_rd_d  = resp_rd_q + (RAW+1)'(resp_pop);
        resp_mem_d = resp_mem_q;
        if (resp_push) begin
            resp_mem_d[resp_wr_q[RAW-1:0]] = bus.i_wb_data[7:0];
        end
        // Counts after this cycle's accept/ack/pop, so a chained read sees its predecessor's reservation.
        resp_after = resp_wr_d - resp_rd_d;
        credit_use = (RAW+2)'(resp_after) + (RAW+2)'(rif_d);
        issue_ok   = head_letter && (out_d < OW'(MAX_OUTSTANDING)) &&
                     (head_lower || (credit_use < (RAW+2)'(RESP_DEPTH)));
    end

    always_comb begin : fsm
        state_d = state_q;
        rx_pop  = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_empty) begin
                    if (!head_letter) begin
                        rx_pop = 1'b1;
                    end else if (issue_ok) begin
                        rx_pop  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (accept) begin
                    if (!rx_empty && issue_ok) begin
                        rx_pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rx_pop && head_letter) begin
            we_d   = head_lower;
            addr_d = ~head_low;
            data_d = head;
        end
    end

    always_comb begin : rx_fifo
        rx_wr_d  = rx_wr_q + (IAW+1)'(rx_push);
        rx_rd_d  = rx_rd_q + (IAW+1)'(rx_pop);
        rx_mem_d = rx_mem_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q[IAW-1:0]] = bus.s_axis_tdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            resp_wr_q <= '0;
            resp_rd_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            out_q     <= '0;
            rif_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            resp_wr_q <= resp_wr_d;
            resp_rd_q <= resp_rd_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            out_q     <= out_d;
            rif_q     <= rif_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge i_clk) begin
        rx_mem_q   <= rx_mem_d;
        resp_mem_q <= resp_mem_d;
    end

    assign bus.s_axis_tready = !rx_full;
    assign bus.m_axis_tdata  = resp_mem_q[resp_rd_q[RAW-1:0]];
    assign bus.m_axis_tvalid = !resp_empty;
    assign bus.o_wb_cyc      = stb || (out_q != '0);
    assign bus.o_wb_stb      = stb;
    assign bus.o_wb_we       = we_q;
    assign bus.o_wb_addr     = WB_ADDR_BITS'(addr_q);
    assign bus.o_wb_data     = WB_DATA_BITS'(data_q);
    assign bus.o_wb_sel      = '1;
    assign bus.o_aux         = AUX_WIDTH'(we_q);
    assign bus.o_outstanding = out_q;
    assign bus.o_err         = err_q;

    assign unused_bits = ^{bus.i_wb_data[WB_DATA_BITS-1:8], bus.i_aux[AUX_WIDTH-1:1]};
endmodule
